// File: rtl/keypad_scan_event.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces the
// synchronized row returns and turns each physical press into one key event.
module keypad_scan_event #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] row_i,
    output logic [3:0] shift_col_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o,
    output logic       key_held_o
);

    // state   | meaning
    // SCAN    | rotating columns, waiting for exactly one row low at a sample
    // CAND    | column parked, counting identical single-key samples
    // PRESSED | event issued, column parked, counting released samples

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CAND    = 2'd1,
        ST_PRESSED = 2'd2
    } state_t;

    localparam int unsigned   DW              = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned   CW              = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [DW-1:0] DWELL_LAST      = DW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TARGET      = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE         = CW'(1);
    localparam logic [CW-1:0] CNT_MAX         = {CW{1'b1}};
    localparam logic [3:0]    COL_FIRST       = 4'b1110;
    localparam bit            ONE_SCAN_ACCEPT = (DEBOUNCE_SCANS <= 1);

    state_t        state_q, state_d;
    logic [3:0]    row_meta_q, row_s_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    cand_row_q, cand_row_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;

    logic          sample;
    logic [2:0]    zero_cnt;
    logic          row_none;
    logic          row_single;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [3:0]    col_rot;
    logic [CW-1:0] match_inc;
    logic [CW-1:0] rel_inc;
    logic          accept;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Rows are asynchronous to clk_i; nothing downstream looks at row_meta_q.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            row_meta_q <= row_i;
            row_s_q    <= row_meta_q;
        end
    end

    always_comb begin
        zero_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            zero_cnt = zero_cnt + {2'b00, ~row_s_q[i]};
        end
    end

    assign row_none   = (zero_cnt == 3'd0);
    assign row_single = (zero_cnt == 3'd1);
    assign sample     = (dwell_q == DWELL_LAST);
    assign col_rot    = {col_q[2:0], col_q[3]};
    assign match_inc  = sat_inc(match_cnt_q);
    assign rel_inc    = sat_inc(rel_cnt_q);

    always_comb begin
        row_idx = 2'd0;
        case (row_s_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        col_idx = 2'd0;
        case (col_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        match_cnt_d = match_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        dwell_d     = sample ? '0 : dwell_q + DW'(1);
        accept      = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (sample) begin
                    if (row_single) begin
                        cand_row_d  = row_idx;
                        match_cnt_d = CNT_ONE;
                        state_d     = ST_CAND;
                        accept      = ONE_SCAN_ACCEPT;
                    end else begin
                        col_d = col_rot;
                    end
                end
            end
            ST_CAND: begin
                if (sample) begin
                    if (row_none) begin
                        state_d     = ST_SCAN;
                        col_d       = col_rot;
                        match_cnt_d = '0;
                    end else if (row_single && (row_idx == cand_row_q)) begin
                        match_cnt_d = match_inc;
                        accept      = (match_inc >= CNT_TARGET);
                    end else if (row_single) begin
                        cand_row_d  = row_idx;
                        match_cnt_d = CNT_ONE;
                        accept      = ONE_SCAN_ACCEPT;
                    end else begin
                        // Ghosting / multi-key: hold the column, restart the streak.
                        match_cnt_d = '0;
                    end
                end
            end
            ST_PRESSED: begin
                if (sample) begin
                    if (row_none) begin
                        rel_cnt_d = rel_inc;
                        if (rel_inc >= CNT_TARGET) begin
                            key_held_d = 1'b0;
                            state_d    = ST_SCAN;
                            col_d      = col_rot;
                            rel_cnt_d  = '0;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase

        if (accept) begin
            state_d     = ST_PRESSED;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            key_code_d  = key_map(row_idx, col_idx);
            match_cnt_d = '0;
            rel_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_SCAN;
            dwell_q     <= '0;
            col_q       <= COL_FIRST;
            cand_row_q  <= 2'd0;
            match_cnt_q <= '0;
            rel_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            cand_row_q  <= cand_row_d;
            match_cnt_q <= match_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign shift_col_o = col_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;
    assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_event.sv
// Bench for keypad_scan_event: a keypad model drives the rows and a
// sample-level reference predicts every output on every cycle.
module tb_keypad_scan_event;
    localparam int SETTLE    = 4;
    localparam int DEB       = 3;
    localparam int MAX_FAILS = 40;
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [3:0]  row_i;
    logic [3:0]  shift_col_o;
    logic        key_valid_o;
    logic [3:0]  key_code_o;
    logic        key_held_o;
    logic [15:0] keys_down = '0;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int n_pulses = 0;
    int m_pulses = 0;
    int last_pulse_cyc = -1;
    logic [3:0] last_code = 4'h0;

    // reference model
    int         m_tick, m_col, m_key, m_streak, m_quiet;
    bit         m_held, m_valid;
    logic [3:0] m_code;
    logic [3:0] m_pipe [$];

    keypad_scan_event #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .row_i       (row_i),
        .shift_col_o (shift_col_o),
        .key_valid_o (key_valid_o),
        .key_code_o  (key_code_o),
        .key_held_o  (key_held_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rows_for(input logic [15:0] keys, input int col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++) if (keys[i*4+col]) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] kb(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_i = 4'hF;
        for (int c = 0; c < 4; c++) if (!shift_col_o[c]) row_i = row_i & rows_for(keys_down, c);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
            if (chk_cnt - pass_cnt >= MAX_FAILS) begin
                $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
                $finish;
            end
        end
    endtask

    function automatic void model_sample(input logic [3:0] rs);
        int zeros, r;
        zeros = 0;
        r = 0;
        for (int i = 0; i < 4; i++) if (!rs[i]) begin zeros++; r = i; end
        if (m_held) begin
            if (zeros == 0) begin
                m_quiet++;
                if (m_quiet >= DEB) begin m_held = 0; m_quiet = 0; m_col = (m_col + 1) % 4; end
            end else m_quiet = 0;
        end else if (zeros == 0) begin
            m_key = -1; m_streak = 0; m_col = (m_col + 1) % 4;
        end else if (zeros > 1) begin
            if (m_key < 0) m_col = (m_col + 1) % 4;
            else m_streak = 0;
        end else begin
            if (m_key == r * 4 + m_col) m_streak++;
            else begin m_key = r * 4 + m_col; m_streak = 1; end
            if (m_streak >= DEB) begin
                m_held = 1; m_valid = 1; m_code = KEYMAP[m_key];
                m_key = -1; m_streak = 0; m_quiet = 0; m_pulses++;
            end
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset_i) begin
                m_tick = 0; m_col = 0; m_key = -1; m_streak = 0; m_quiet = 0;
                m_held = 0; m_valid = 0; m_code = 4'h0; cyc = 0;
                m_pipe = '{4'hF, 4'hF};
            end else begin
                logic [3:0] rs;
                rs = m_pipe.pop_front();
                m_pipe.push_back(rows_for(keys_down, m_col));
                m_valid = 0;
                if (m_tick % SETTLE == SETTLE - 1) model_sample(rs);
                m_tick++;
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = 4'hF;
            exp_col[m_col] = 1'b0;
            check("shift_col", 32'(shift_col_o), 32'(exp_col));
            check("key_valid", 32'(key_valid_o), 32'(m_valid));
            check("key_held", 32'(key_held_o), 32'(m_held));
            check("key_code", 32'(key_code_o), 32'(m_code));
            if (key_valid_o) begin
                n_pulses++;
                last_pulse_cyc = cyc;
                last_code = key_code_o;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        int start, n;
        start = n_pulses;
        n = 0;
        while (n_pulses == start && n < budget) begin cycles(1); n++; end
        check(tag, 32'(n_pulses != start), 32'(1));
    endtask

    initial begin
        int base, d;
        logic [3:0] exp_col;
        cycles(3);
        check("rst_col", 32'(shift_col_o), 32'(4'b1110));
        check("rst_valid", 32'(key_valid_o), 32'(0));
        check("rst_code", 32'(key_code_o), 32'(0));
        check("rst_held", 32'(key_held_o), 32'(0));

        // '5' held from cycle 0: samples at 7, 11, 15, event at 16
        keys_down = kb(1, 1);
        reset_i = 1'b0;
        base = n_pulses;
        cycles(216);
        check("k5_count", 32'(n_pulses - base), 32'(1));
        check("k5_cycle", 32'(last_pulse_cyc), 32'(16));
        check("k5_code", 32'(last_code), 32'(4'h5));
        check("k5_held", 32'(key_held_o), 32'(1));
        keys_down = '0;
        cycles(40);
        check("k5_released", 32'(key_held_o), 32'(0));

        // '#' twice, with release-debounce timing
        base = n_pulses;
        keys_down = kb(3, 2);
        wait_pulse("hash1_seen", 80);
        check("hash1_code", 32'(last_code), 32'(4'hF));
        cycles(40);
        keys_down = '0;
        d = 0;
        while (key_held_o && d < 40) begin cycles(1); d++; end
        check("hash_rel_window", 32'(d >= 11 && d <= 14), 32'(1));
        cycles(10);
        keys_down = kb(3, 2);
        wait_pulse("hash2_seen", 80);
        check("hash2_code", 32'(last_code), 32'(4'hF));
        cycles(30);
        check("hash_count", 32'(n_pulses - base), 32'(2));
        keys_down = '0;
        cycles(40);

        // bounce on '1': segments too short for three matching samples
        base = n_pulses;
        for (int i = 0; i < 6; i++) begin
            keys_down = (i % 2 == 0) ? kb(0, 0) : 16'h0;
            cycles(int'($urandom_range(2, 5)));
        end
        check("bounce_quiet", 32'(n_pulses - base), 32'(0));
        keys_down = kb(0, 0);
        wait_pulse("bounce_seen", 60);
        check("bounce_code", 32'(last_code), 32'(4'h1));
        cycles(50);
        check("bounce_count", 32'(n_pulses - base), 32'(1));
        keys_down = '0;
        cycles(40);

        // ghost: '2' and '8' share col1
        base = n_pulses;
        keys_down = kb(0, 1) | kb(2, 1);
        cycles(100);
        check("ghost_quiet", 32'(n_pulses - base), 32'(0));
        keys_down = kb(0, 1);
        wait_pulse("ghost_seen", 60);
        check("ghost_code", 32'(last_code), 32'(4'h2));
        keys_down = '0;
        cycles(40);

        // reset two cycles into PRESSED with '9' still down
        keys_down = kb(2, 2);
        wait_pulse("nine_seen", 80);
        cycles(2);
        reset_i = 1'b1;
        cycles(1);
        check("midrst_col", 32'(shift_col_o), 32'(4'b1110));
        check("midrst_valid", 32'(key_valid_o), 32'(0));
        check("midrst_code", 32'(key_code_o), 32'(0));
        check("midrst_held", 32'(key_held_o), 32'(0));
        reset_i = 1'b0;
        wait_pulse("nine_again", 80);
        check("nine_code", 32'(last_code), 32'(4'h9));
        keys_down = '0;
        cycles(40);

        // idle rotation
        reset_i = 1'b1;
        cycles(1);
        reset_i = 1'b0;
        base = n_pulses;
        for (int k = 0; k < 5; k++) begin
            exp_col = 4'hF;
            exp_col[k % 4] = 1'b0;
            check("idle_col", 32'(shift_col_o), 32'(exp_col));
            cycles(SETTLE);
        end
        cycles(80);
        check("idle_quiet", 32'(n_pulses - base), 32'(0));

        // random presses, occasional second key and mid-press reset
        for (int it = 0; it < 40; it++) begin
            logic [15:0] m;
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) m = m | (16'(1) << $urandom_range(0, 15));
            keys_down = m;
            cycles(int'($urandom_range(4, 80)));
            if ($urandom_range(0, 7) == 0) begin
                reset_i = 1'b1;
                cycles(1);
                reset_i = 1'b0;
            end
            keys_down = '0;
            cycles(int'($urandom_range(4, 60)));
        end
        check("rand_pulse_total", 32'(n_pulses), 32'(m_pulses));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
